// File: rtl/coin_game_pkg.sv
// Shared types and constants for the coin-catch game controller and its end-screen ROM.
package coin_game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } game_state_t;

    localparam int PLATE_W = 3;

    // Scan slot is {layer, col}; in PLAY it visits plate, green, red layers of 8 columns each.
    localparam logic [1:0] LAYER_PLATE = 2'd0;
    localparam logic [1:0] LAYER_GREEN = 2'd1;
    localparam logic [1:0] LAYER_RED   = 2'd2;
    localparam logic [4:0] SCAN_LAST   = 5'd23;

    // Active-low row patterns indexed by column ([7] listed first).
    localparam logic [7:0][7:0] WIN_DIAMOND = {
        8'hE7, 8'hC3, 8'h81, 8'h00, 8'h00, 8'h81, 8'hC3, 8'hE7
    };
    localparam logic [7:0][7:0] LOSE_X = {
        8'h7E, 8'hBD, 8'hDB, 8'hE7, 8'hE7, 8'hDB, 8'hBD, 8'h7E
    };

    // True when column col lies under a plate whose leftmost column is left.
    function automatic logic in_plate(input logic [2:0] col, input logic [2:0] left);
        logic [3:0] right;
        right = {1'b0, left} + 4'(PLATE_W - 1);
        return ({1'b0, col} >= {1'b0, left}) && ({1'b0, col} <= right);
    endfunction

endpackage

// File: rtl/end_screen_rom.sv
// Maps (game state, column) to the WIN diamond and LOSE cross; other states give a blank column.
module end_screen_rom
    import coin_game_pkg::*;
(
    input  game_state_t game_state,
    input  logic [2:0]  col,
    output logic [7:0]  data_r,
    output logic [7:0]  data_g,
    output logic [7:0]  data_b
);

    always_comb begin
        data_r = 8'hFF;
        data_g = 8'hFF;
        data_b = 8'hFF;
        case (game_state)
            WIN:     data_b = WIN_DIAMOND[col];
            LOSE:    data_r = LOSE_X[col];
            default: ;
        endcase
    end

endmodule

// File: rtl/coin_game_ctrl.sv
// Coin-catch game controller: play FSM, scoring, respawn requests and a registered
// column scan of the 8x8 RGB matrix (outputs load from the current slot on scan_tick).
module coin_game_ctrl
    import coin_game_pkg::*;
#(
    parameter int WIN_SCORE = 20,
    parameter int GREEN_PTS = 1,
    parameter int RED_PTS   = 2
) (
    input  logic       CLK,
    input  logic       Clear,
    input  logic       start,
    input  logic       scan_tick,
    input  logic       fall_tick,
    input  logic [2:0] plate_x,
    input  logic       green_vld,
    input  logic [2:0] green_col,
    input  logic [7:0] green_pos,
    input  logic       red_vld,
    input  logic [2:0] red_col,
    input  logic [7:0] red_pos,
    output logic [7:0] DATA_R,
    output logic [7:0] DATA_G,
    output logic [7:0] DATA_B,
    output logic [2:0] S,
    output logic       COMM,
    output logic [4:0] score,
    output logic [1:0] state,
    output logic       green_respawn,
    output logic       red_respawn
);

    game_state_t game_q, game_d;
    logic [4:0]  score_q, score_d;
    logic [4:0]  scan_q, scan_d;
    logic [7:0]  data_r_q, data_g_q, data_b_q;
    logic [7:0]  data_r_d, data_g_d, data_b_d;
    logic [2:0]  s_q, s_d;
    logic        green_resp_q, green_resp_d;
    logic        red_resp_q, red_resp_d;

    logic [1:0]  layer;
    logic [2:0]  col;
    logic [7:0]  end_r, end_g, end_b;
    logic [7:0]  frame_r, frame_g, frame_b;
    logic [2:0]  frame_s;

    logic        green_land, red_land;
    logic        green_catch, red_catch, green_miss, red_miss;
    logic [5:0]  sum;

    assign layer = scan_q[4:3];
    assign col   = scan_q[2:0];

    // A coin is judged only when it has reached the plate row.
    assign green_land  = green_vld && (green_pos == 8'h80);
    assign red_land    = red_vld && (red_pos == 8'h80);
    assign green_catch = green_land && in_plate(green_col, plate_x);
    assign red_catch   = red_land && in_plate(red_col, plate_x);
    assign green_miss  = green_land && !in_plate(green_col, plate_x);
    assign red_miss    = red_land && !in_plate(red_col, plate_x);

    assign sum = {1'b0, score_q}
               + (green_catch ? 6'(GREEN_PTS) : 6'd0)
               + (red_catch   ? 6'(RED_PTS)   : 6'd0);

    end_screen_rom u_end_screen_rom (
        .game_state (game_q),
        .col        (col),
        .data_r     (end_r),
        .data_g     (end_g),
        .data_b     (end_b)
    );

    // Column image for the slot currently held in the scan counter.
    always_comb begin
        frame_r = 8'hFF;
        frame_g = 8'hFF;
        frame_b = 8'hFF;
        frame_s = 3'd0;
        case (game_q)
            PLAY: begin
                frame_s = col;
                case (layer)
                    LAYER_PLATE: if (in_plate(col, plate_x)) frame_b = 8'h7F;
                    LAYER_GREEN: if (green_vld && col == green_col) frame_g = ~green_pos;
                    LAYER_RED:   if (red_vld && col == red_col) frame_r = ~red_pos;
                    default:     ;
                endcase
            end
            WIN, LOSE: begin
                frame_s = col;
                frame_r = end_r;
                frame_g = end_g;
                frame_b = end_b;
            end
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        game_d       = game_q;
        score_d      = score_q;
        scan_d       = scan_q;
        green_resp_d = 1'b0;
        red_resp_d   = 1'b0;
        data_r_d     = data_r_q;
        data_g_d     = data_g_q;
        data_b_d     = data_b_q;
        s_d          = s_q;

        if (scan_tick) begin
            data_r_d = frame_r;
            data_g_d = frame_g;
            data_b_d = frame_b;
            s_d      = frame_s;
        end

        case (game_q)
            IDLE: begin
                scan_d = 5'd0;
                if (start) begin
                    game_d  = PLAY;
                    score_d = 5'd0;
                end
            end
            PLAY: begin
                if (scan_tick) scan_d = (scan_q == SCAN_LAST) ? 5'd0 : scan_q + 5'd1;
                if (fall_tick) begin
                    // A miss wins over any simultaneous catch: no points, no respawn.
                    if (green_miss || red_miss) begin
                        game_d = LOSE;
                    end else if (green_catch || red_catch) begin
                        green_resp_d = green_catch;
                        red_resp_d   = red_catch;
                        if (sum >= 6'(WIN_SCORE)) begin
                            score_d = 5'(WIN_SCORE);
                            game_d  = WIN;
                        end else begin
                            score_d = sum[4:0];
                        end
                    end
                end
            end
            WIN, LOSE: begin
                if (scan_tick) scan_d = {2'b00, col + 3'd1};
                if (start) begin
                    game_d  = PLAY;
                    score_d = 5'd0;
                    scan_d  = 5'd0;
                end
            end
            default: game_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (Clear) begin
            game_q       <= IDLE;
            score_q      <= 5'd0;
            scan_q       <= 5'd0;
            data_r_q     <= 8'hFF;
            data_g_q     <= 8'hFF;
            data_b_q     <= 8'hFF;
            s_q          <= 3'd0;
            green_resp_q <= 1'b0;
            red_resp_q   <= 1'b0;
        end else begin
            game_q       <= game_d;
            score_q      <= score_d;
            scan_q       <= scan_d;
            data_r_q     <= data_r_d;
            data_g_q     <= data_g_d;
            data_b_q     <= data_b_d;
            s_q          <= s_d;
            green_resp_q <= green_resp_d;
            red_resp_q   <= red_resp_d;
        end
    end

    assign DATA_R        = data_r_q;
    assign DATA_G        = data_g_q;
    assign DATA_B        = data_b_q;
    assign S             = s_q;
    assign COMM          = 1'b1;
    assign score         = score_q;
    assign state         = game_q;
    assign green_respawn = green_resp_q;
    assign red_respawn   = red_resp_q;

endmodule

// File: tb/tb_coin_game_ctrl.sv
// Scoreboard bench for coin_game_ctrl: a game-level reference model predicts every cycle's
// outputs into a queue, and a monitor pops and compares them one cycle later.
module tb_coin_game_ctrl;

    localparam int WIN_SCORE = 20;
    localparam int GREEN_PTS = 1;
    localparam int RED_PTS   = 2;
    localparam int ST_IDLE = 0, ST_PLAY = 1, ST_WIN = 2, ST_LOSE = 3;

    logic       CLK = 1'b0;
    logic       Clear, start, scan_tick, fall_tick;
    logic [2:0] plate_x;
    logic       green_vld, red_vld;
    logic [2:0] green_col, red_col;
    logic [7:0] green_pos, red_pos;
    logic [7:0] DATA_R, DATA_G, DATA_B;
    logic [2:0] S;
    logic       COMM;
    logic [4:0] score;
    logic [1:0] state;
    logic       green_respawn, red_respawn;

    coin_game_ctrl #(
        .WIN_SCORE (WIN_SCORE),
        .GREEN_PTS (GREEN_PTS),
        .RED_PTS   (RED_PTS)
    ) dut (
        .CLK           (CLK),
        .Clear         (Clear),
        .start         (start),
        .scan_tick     (scan_tick),
        .fall_tick     (fall_tick),
        .plate_x       (plate_x),
        .green_vld     (green_vld),
        .green_col     (green_col),
        .green_pos     (green_pos),
        .red_vld       (red_vld),
        .red_col       (red_col),
        .red_pos       (red_pos),
        .DATA_R        (DATA_R),
        .DATA_G        (DATA_G),
        .DATA_B        (DATA_B),
        .S             (S),
        .COMM          (COMM),
        .score         (score),
        .state         (state),
        .green_respawn (green_respawn),
        .red_respawn   (red_respawn)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int st, sc, s, r, g, b, gresp, rresp;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: game state, score, scan slot (0..23) and the visible outputs.
    int m_state, m_score, m_slot, m_s, m_r, m_g, m_b, m_gresp, m_rresp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    // Advance the model by one clock using the inputs now on the pins; queue the prediction.
    task automatic model_step();
        exp_t e;
        int   col, layer, d, px, pts;
        int   n_state, n_score, n_slot;
        bit   g_land, r_land, g_in, r_in;
        px      = plate_x;
        col     = m_slot % 8;
        layer   = m_slot / 8;
        n_state = m_state;
        n_score = m_score;
        n_slot  = m_slot;
        m_gresp = 0;
        m_rresp = 0;
        if (Clear) begin
            n_state = ST_IDLE; n_score = 0; n_slot = 0;
            m_r = 255; m_g = 255; m_b = 255; m_s = 0;
        end else begin
            if (scan_tick) begin
                m_r = 255; m_g = 255; m_b = 255; m_s = 0;
                if (m_state == ST_PLAY) begin
                    m_s = col;
                    if (layer == 0 && col >= px && col <= px + 2) m_b = 127;
                    if (layer == 1 && green_vld && col == green_col) m_g = 255 - green_pos;
                    if (layer == 2 && red_vld && col == red_col) m_r = 255 - red_pos;
                    n_slot = (m_slot + 1) % 24;
                end else if (m_state == ST_WIN) begin
                    m_s = col;
                    d = (col < 4) ? col : 7 - col;
                    for (int row = 0; row < 8; row++)
                        if (row >= 3 - d && row <= 4 + d) m_b -= (1 << row);
                    n_slot = (col + 1) % 8;
                end else if (m_state == ST_LOSE) begin
                    m_s = col;
                    m_r = 255 - ((1 << col) | (1 << (7 - col)));
                    n_slot = (col + 1) % 8;
                end
            end
            if (m_state == ST_PLAY) begin
                if (fall_tick) begin
                    g_land = green_vld && green_pos == 8'h80;
                    r_land = red_vld && red_pos == 8'h80;
                    g_in   = green_col >= px && green_col <= px + 2;
                    r_in   = red_col >= px && red_col <= px + 2;
                    if ((g_land && !g_in) || (r_land && !r_in)) begin
                        n_state = ST_LOSE;
                    end else begin
                        pts = (g_land ? GREEN_PTS : 0) + (r_land ? RED_PTS : 0);
                        if (pts > 0) begin
                            m_gresp = g_land;
                            m_rresp = r_land;
                            if (m_score + pts >= WIN_SCORE) begin
                                n_score = WIN_SCORE;
                                n_state = ST_WIN;
                            end else begin
                                n_score = m_score + pts;
                            end
                        end
                    end
                end
            end else if (start) begin
                n_state = ST_PLAY; n_score = 0; n_slot = 0;
            end
        end
        m_state = n_state;
        m_score = n_score;
        m_slot  = n_slot;
        e.st = m_state; e.sc = m_score; e.s = m_s;
        e.r = m_r; e.g = m_g; e.b = m_b;
        e.gresp = m_gresp; e.rresp = m_rresp;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(negedge CLK);
    endtask

    task automatic quiet();
        Clear = 0; start = 0; scan_tick = 0; fall_tick = 0;
        green_vld = 0; red_vld = 0;
        green_col = 0; red_col = 0; green_pos = 8'h01; red_pos = 8'h01;
    endtask

    task automatic land(input bit gv, input int gc, input bit rv, input int rc);
        quiet();
        fall_tick = 1; plate_x = 3'd2;
        green_vld = gv; green_col = 3'(gc); green_pos = 8'h80;
        red_vld = rv; red_col = 3'(rc); red_pos = 8'h80;
        tick();
        quiet();
        tick();
    endtask

    task automatic scan_run(input int n);
        for (int i = 0; i < n; i++) begin
            quiet();
            scan_tick = 1; plate_x = 3'd2;
            green_vld = 1; green_col = 3'd5; green_pos = 8'(1 << (i % 7));
            red_vld = 1; red_col = 3'd1; red_pos = 8'h10;
            tick();
        end
    endtask

    task automatic pulse_start();
        quiet(); start = 1; tick(); quiet(); tick();
    endtask

    // Monitor: every cycle the DUT presents a new output set; compare it with the oldest prediction.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty at %0t: got no prediction expected one", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("state", state, mon_e.st);
                check("score", score, mon_e.sc);
                check("S", S, mon_e.s);
                check("DATA_R", DATA_R, mon_e.r);
                check("DATA_G", DATA_G, mon_e.g);
                check("DATA_B", DATA_B, mon_e.b);
                check("COMM", COMM, 1);
                check("green_respawn", green_respawn, mon_e.gresp);
                check("red_respawn", red_respawn, mon_e.rresp);
            end
        end
    end

    initial begin
        m_state = ST_IDLE; m_score = 0; m_slot = 0;
        m_s = 0; m_r = 255; m_g = 255; m_b = 255; m_gresp = 0; m_rresp = 0;
        quiet();
        plate_x = 3'd2;
        Clear = 1;
        tick();
        Clear = 1; start = 1; fall_tick = 1; scan_tick = 1;
        tick();
        quiet();
        scan_run(3);

        pulse_start();
        land(1, 3, 0, 0);
        land(1, 3, 0, 0);
        scan_run(26);
        land(1, 4, 0, 0);
        land(1, 2, 0, 0);
        land(1, 2, 1, 4);
        for (int i = 0; i < 12; i++) land(1, 2 + (i % 3), 0, 0);
        land(0, 0, 1, 3);
        scan_run(10);

        pulse_start();
        land(1, 3, 1, 6);
        scan_run(10);

        pulse_start();
        land(1, 4, 0, 0);
        quiet();
        Clear = 1; fall_tick = 1; scan_tick = 1; plate_x = 3'd2;
        green_vld = 1; green_col = 3'd3; green_pos = 8'h80;
        tick();
        quiet();
        tick();
        scan_run(4);

        for (int i = 0; i < 3000; i++) begin
            int px;
            px = $urandom_range(0, 5);
            Clear     = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 39) == 0);
            scan_tick = $urandom_range(0, 1) == 1;
            fall_tick = ($urandom_range(0, 2) == 0);
            plate_x   = 3'(px);
            green_vld = $urandom_range(0, 3) != 0;
            red_vld   = $urandom_range(0, 3) != 0;
            green_col = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                                    : 3'(px + $urandom_range(0, 2));
            red_col   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                                    : 3'(px + $urandom_range(0, 2));
            green_pos = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'(1 << $urandom_range(0, 7));
            red_pos   = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'(1 << $urandom_range(0, 7));
            tick();
        end
        quiet();
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
